// File: rtl/soc_test_pkg.sv
// Shared register map, FSM encoding and STATUS layout for the SoC test-control peripheral.
package soc_test_pkg;

  localparam logic [4:0] REG_STATUS  = 5'h00;
  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_TOHOST  = 5'h04;
  localparam logic [4:0] REG_CYCLE   = 5'h08;
  localparam logic [4:0] REG_TIMEOUT = 5'h0C;
  localparam logic [4:0] REG_LED     = 5'h10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam int unsigned STATUS_DONE_BIT    = 0;
  localparam int unsigned STATUS_PASS_BIT    = 1;
  localparam int unsigned STATUS_TIMEOUT_BIT = 2;
  localparam int unsigned STATUS_RUN_BIT     = 3;

  function automatic logic [31:0] status_word(input logic run, input logic tmo,
                                              input logic pass, input logic done);
    logic [31:0] w;
    w = '0;
    w[STATUS_RUN_BIT]     = run;
    w[STATUS_TIMEOUT_BIT] = tmo;
    w[STATUS_PASS_BIT]    = pass;
    w[STATUS_DONE_BIT]    = done;
    return w;
  endfunction

endpackage

// File: rtl/soc_test_watchdog.sv
// Saturating run-length counter with a compare against a programmable limit.
module soc_test_watchdog #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q;
    if (clear_i) begin
      cycle_d = '0;
    end else if (run_i && (cycle_q != '1)) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_o = cycle_q;
  // A zero limit disables the watchdog entirely.
  assign expire_o = run_i && (limit_i != '0) && (cycle_q == limit_i - CNT_W'(1));

endmodule

// File: rtl/soc_test_ctrl.sv
// Memory-mapped test-control peripheral: firmware exit code, watchdog, cycle counter and LEDs.
module soc_test_ctrl
  import soc_test_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
  parameter int unsigned LED_W          = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic [LED_W-1:0] led,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      exit_code
);

  state_e           state_q;
  logic             served_q;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic [LED_W-1:0] led_q;
  logic             done_q, pass_q, timeout_q;
  logic [30:0]      exit_q;
  logic [CNT_W-1:0] limit_q;

  logic             sel, ack, wr, restart, tohost, running, expire;
  logic [4:0]       off;
  logic [CNT_W-1:0] cycle;
  logic [31:0]      rdata_d;

  assign sel     = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  // served_q blocks a second ack until the master drops mem_valid.
  assign ack     = sel && !served_q;
  assign off     = mem_addr[4:0];
  assign wr      = ack && (mem_wstrb == 4'hF);
  assign running = (state_q == ST_RUN);
  assign restart = wr && (off == REG_CTRL) && mem_wdata[0];
  assign tohost  = wr && (off == REG_TOHOST) && mem_wdata[0] && running;

  soc_test_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .run_i   (running),
    .clear_i (restart),
    .limit_i (limit_q),
    .cycle_o (cycle),
    .expire_o(expire)
  );

  always_comb begin
    rdata_d = '0;
    case (off)
      REG_STATUS:  rdata_d = status_word(running, timeout_q, pass_q, done_q);
      REG_TOHOST:  rdata_d = {exit_q, done_q};
      REG_CYCLE:   rdata_d = 32'(cycle);
      REG_TIMEOUT: rdata_d = 32'(limit_q);
      REG_LED:     rdata_d = 32'(led_q);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      served_q  <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
      limit_q   <= CNT_W'(TIMEOUT_CYCLES);
    end else begin
      ready_q <= ack;
      rdata_q <= ack ? rdata_d : '0;
      if (ack) begin
        served_q <= 1'b1;
      end else if (!mem_valid) begin
        served_q <= 1'b0;
      end
      if (wr && (off == REG_TIMEOUT)) begin
        limit_q <= mem_wdata[CNT_W-1:0];
      end
      if (wr && (off == REG_LED)) begin
        led_q <= mem_wdata[LED_W-1:0];
      end
      // Priority: restart, then firmware completion, then watchdog expiry.
      if (restart) begin
        state_q   <= ST_RUN;
        done_q    <= 1'b0;
        pass_q    <= 1'b0;
        timeout_q <= 1'b0;
        exit_q    <= '0;
      end else if (tohost) begin
        state_q <= ST_DONE;
        done_q  <= 1'b1;
        pass_q  <= (mem_wdata[31:1] == 31'd0);
        exit_q  <= mem_wdata[31:1];
      end else if (expire) begin
        state_q   <= ST_TIMEOUT;
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign led       = led_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_q;

endmodule
